// File: rtl/wb_ctrl_pkg.sv
// wb_ctrl_pkg: shared types and constants for the white balance control sequencer
package wb_ctrl_pkg;
  typedef enum logic [1:0] {
    WB_BYPASS = 2'd0,
    WB_MANUAL = 2'd1,
    WB_AUTO   = 2'd2,
    WB_HOLD   = 2'd3
  } wb_mode_e;
  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR0,
    ST_WR1,
    ST_WR2,
    ST_LOCK,
    ST_RB_SEL,
    ST_RB_WAIT,
    ST_RB_DONE
  } wb_state_e;
endpackage

// File: rtl/wb_ctrl_if.sv
// wb_ctrl_if: control bus between the sequencer and the white balance corrector
interface wb_ctrl_if;
  logic [1:0]  mode;
  logic        cal_stb;
  logic [1:0]  man_sel;
  logic [31:0] man_coef;
  logic        man_lock;
  logic [31:0] cur_coef;
  modport master (output mode, cal_stb, man_sel, man_coef, man_lock, input cur_coef);
  modport slave (input mode, cal_stb, man_sel, man_coef, man_lock, output cur_coef);
endinterface

// File: rtl/wb_frame_sched.sv
// wb_frame_sched: frame-boundary mode latch, AUTO calibration period counter and cal_stb pulse
module wb_frame_sched
  import wb_ctrl_pkg::*;
#(
  parameter int CAL_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sof_i,
  input  logic [1:0]           mode_i,
  input  logic [CAL_CNT_W-1:0] cal_period_i,
  input  logic                 cal_req_i,
  output logic [1:0]           mode_o,
  output logic                 cal_stb_o,
  output logic                 cal_pend_o
);
  wb_mode_e             mode_q, mode_d;
  logic [CAL_CNT_W-1:0] frm_cnt_q, frm_cnt_d, last_cnt;
  logic                 cal_pend_q, cal_pend_d, cal_fire_q, cal_fire_d;
  logic                 auto_new, wrap, pend_now;
  always_comb begin
    auto_new   = wb_mode_e'(mode_i) == WB_AUTO;
    last_cnt   = (cal_period_i == '0) ? '0 : cal_period_i - CAL_CNT_W'(1);
    // >= keeps the counter bounded if the period shrinks below the running count
    wrap       = auto_new && (frm_cnt_q >= last_cnt);
    pend_now   = cal_pend_q | cal_req_i;
    mode_d     = sof_i ? wb_mode_e'(mode_i) : mode_q;
    frm_cnt_d  = !sof_i ? frm_cnt_q : (!auto_new || wrap) ? '0 : frm_cnt_q + CAL_CNT_W'(1);
    cal_fire_d = sof_i && (wrap || (pend_now && wb_mode_e'(mode_i) != WB_BYPASS));
    cal_pend_d = sof_i ? 1'b0 : pend_now;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q     <= WB_BYPASS;
      frm_cnt_q  <= '0;
      cal_pend_q <= 1'b0;
      cal_fire_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      frm_cnt_q  <= frm_cnt_d;
      cal_pend_q <= cal_pend_d;
      cal_fire_q <= cal_fire_d;
    end
  end
  assign mode_o     = mode_q;
  assign cal_stb_o  = cal_fire_q;
  assign cal_pend_o = cal_pend_q;
endmodule

// File: rtl/wb_ctrl_sequencer.sv
// wb_ctrl_sequencer: frame-synchronous manual coefficient load and coefficient readback master
module wb_ctrl_sequencer
  import wb_ctrl_pkg::*;
#(
  parameter int CAL_CNT_W = 8,
  parameter int RB_LAT    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sof_i,
  input  logic [1:0]           mode_i,
  input  logic [CAL_CNT_W-1:0] cal_period_i,
  input  logic                 cal_req_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [31:0]          cfg_coef_r_i,
  input  logic [31:0]          cfg_coef_g_i,
  input  logic [31:0]          cfg_coef_b_i,
  input  logic                 rb_req_i,
  output logic                 rb_valid_o,
  output logic [31:0]          rb_coef_r_o,
  output logic [31:0]          rb_coef_g_o,
  output logic [31:0]          rb_coef_b_o,
  output logic                 busy_o,
  wb_ctrl_if.master            wb_ctrl
);
  wb_state_e   state_q, state_d;
  logic [1:0]  ch_q, ch_d, man_sel_q, man_sel_d, mode;
  logic [2:0]  wait_q, wait_d;
  logic        load_pend_q, load_pend_d, rb_pend_q, rb_pend_d, cfg_ready_q, cfg_ready_d;
  logic        man_lock_q, rb_valid_q, cal_stb, cal_pend;
  logic [31:0] man_coef_q, man_coef_d;
  logic [31:0] shadow_q [3];
  logic [31:0] shadow_d [3];
  logic [31:0] rb_coef_q [3];
  logic [31:0] rb_coef_d [3];
  wb_frame_sched #(.CAL_CNT_W(CAL_CNT_W)) u_sched (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .sof_i        (sof_i),
    .mode_i       (mode_i),
    .cal_period_i (cal_period_i),
    .cal_req_i    (cal_req_i),
    .mode_o       (mode),
    .cal_stb_o    (cal_stb),
    .cal_pend_o   (cal_pend)
  );
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    wait_d      = wait_q;
    load_pend_d = load_pend_q;
    rb_pend_d   = rb_pend_q | rb_req_i;
    cfg_ready_d = cfg_ready_q;
    shadow_d    = shadow_q;
    rb_coef_d   = rb_coef_q;
    man_sel_d   = man_sel_q;
    man_coef_d  = man_coef_q;
    if (cfg_valid_i && cfg_ready_q) begin
      shadow_d    = '{cfg_coef_r_i, cfg_coef_g_i, cfg_coef_b_i};
      load_pend_d = 1'b1;
      cfg_ready_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        state_d = (sof_i && load_pend_q) ? ST_WR0 : rb_pend_q ? ST_RB_SEL : ST_IDLE;
        ch_d    = CH_R;
      end
      ST_WR0: state_d = ST_WR1;
      ST_WR1: state_d = ST_WR2;
      ST_WR2: state_d = ST_LOCK;
      ST_LOCK: begin
        state_d     = ST_IDLE;
        load_pend_d = 1'b0;
        cfg_ready_d = 1'b1;
      end
      ST_RB_SEL: begin
        state_d = ST_RB_WAIT;
        wait_d  = 3'(RB_LAT);
      end
      ST_RB_WAIT: begin
        wait_d = wait_q - 3'd1;
        // last wait cycle: cur_coef has settled RB_LAT cycles after man_sel moved
        if (wait_q == 3'd1) begin
          rb_coef_d[ch_q] = wb_ctrl.cur_coef;
          ch_d            = ch_q + 2'd1;
          state_d         = (ch_q == CH_B) ? ST_RB_DONE : ST_RB_SEL;
        end
      end
      ST_RB_DONE: begin
        state_d   = ST_IDLE;
        rb_pend_d = 1'b0;
      end
    endcase
    case (state_d)
      ST_WR0: begin
        man_sel_d  = CH_R;
        man_coef_d = shadow_q[CH_R];
      end
      ST_WR1: begin
        man_sel_d  = CH_G;
        man_coef_d = shadow_q[CH_G];
      end
      ST_WR2: begin
        man_sel_d  = CH_B;
        man_coef_d = shadow_q[CH_B];
      end
      ST_RB_SEL: man_sel_d = ch_d;
      default: ;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ch_q        <= CH_R;
      wait_q      <= '0;
      load_pend_q <= 1'b0;
      rb_pend_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
      shadow_q    <= '{default: '0};
      rb_coef_q   <= '{default: '0};
      man_sel_q   <= '0;
      man_coef_q  <= '0;
      man_lock_q  <= 1'b0;
      rb_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      wait_q      <= wait_d;
      load_pend_q <= load_pend_d;
      rb_pend_q   <= rb_pend_d;
      cfg_ready_q <= cfg_ready_d;
      shadow_q    <= shadow_d;
      rb_coef_q   <= rb_coef_d;
      man_sel_q   <= man_sel_d;
      man_coef_q  <= man_coef_d;
      man_lock_q  <= state_d == ST_LOCK;
      rb_valid_q  <= state_q == ST_RB_DONE;
    end
  end
  assign cfg_ready_o      = cfg_ready_q;
  assign rb_valid_o       = rb_valid_q;
  assign rb_coef_r_o      = rb_coef_q[CH_R];
  assign rb_coef_g_o      = rb_coef_q[CH_G];
  assign rb_coef_b_o      = rb_coef_q[CH_B];
  assign busy_o           = (state_q != ST_IDLE) | load_pend_q | rb_pend_q | cal_pend;
  assign wb_ctrl.mode     = mode;
  assign wb_ctrl.cal_stb  = cal_stb;
  assign wb_ctrl.man_sel  = man_sel_q;
  assign wb_ctrl.man_coef = man_coef_q;
  assign wb_ctrl.man_lock = man_lock_q;
endmodule
